multicycle_control: RTL and testbench

Control FSM for the multicycle MIPS-subset datapath. It sequences the shared register file, memory, instruction register, PC and the single ALU. Each cycle it drives ALU operand selects and the 3-bit ALU operation code, plus all datapath write enables. It steps through fetch, decode, execute, memory and writeback states per instruction, and it alone decides when the ALU computes PC+4, addresses, R-type results and branch comparisons.

---
 rtl/multicycle_control.sv | 188 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Control FSM for the multicycle MIPS-subset datapath: sequences fetch, decode,
// execute, memory and writeback, steering the shared ALU and all write enables.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic [3:0] state,
  output logic       instr_done
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;

  state_t     state_q, state_d;
  state_t     cur;
  logic       funct_ok;
  logic [2:0] funct_alu;
  logic       pc_write;
  logic       branch;

  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = 3'b000;
    case (funct)
      FN_ADD:  funct_alu = 3'b000;
      FN_SUB:  funct_alu = 3'b001;
      FN_AND:  funct_alu = 3'b010;
      FN_OR:   funct_alu = 3'b011;
      default: funct_ok  = 1'b0;
    endcase
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = funct_ok ? S_EXECUTE : S_FETCH;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: state_d = S_MEMWB;
      S_EXECUTE: state_d = S_ALUWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      default:   state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Reset overrides the visible state so the datapath sees FETCH selects at once.
  assign cur = reset ? S_FETCH : state_q;

  always_comb begin
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = 3'b000;
    PCSrc      = 2'b00;
    pc_write   = 1'b0;
    branch     = 1'b0;
    instr_done = 1'b0;
    case (cur)
      S_FETCH: begin
        IRWrite  = 1'b1;
        ALUSrcB  = 2'b01;
        pc_write = 1'b1;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        // Unsupported opcode/funct retires here as a nop.
        case (op)
          OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: instr_done = 1'b0;
          OP_RTYPE: instr_done = ~funct_ok;
          default:  instr_done = 1'b1;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMREAD: IorD = 1'b1;
      S_MEMWB: begin
        MemtoReg   = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        IorD       = 1'b1;
        MemWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_EXECUTE: begin
        ALUSrcA    = 1'b1;
        ALUControl = funct_alu;
      end
      S_ALUWB: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = 3'b001;
        PCSrc      = 2'b01;
        branch     = 1'b1;
        instr_done = 1'b1;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_ADDIWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        PCSrc      = 2'b10;
        pc_write   = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      pc_write   = 1'b0;
      branch     = 1'b0;
      instr_done = 1'b0;
    end
  end

  assign PCEn  = pc_write | (branch & zero);
  assign state = cur;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: instruction-level model (state list per opcode)
// compared every cycle, plus directed literal checks.
module tb_multicycle_control;
  logic       clk, reset, zero;
  logic [5:0] op, funct;
  logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUControl;
  logic       PCEn, instr_done;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  multicycle_control dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .PCSrc(PCSrc), .PCEn(PCEn),
    .state(state), .instr_done(instr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [16:0] dut_vec;
  assign dut_vec = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                    ALUSrcB, ALUControl, PCSrc, PCEn, instr_done};

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: remaining states of the current instruction after FETCH.
  int m_cur = 0;
  int m_q[$];

  function automatic bit fn_ok(input logic [5:0] f);
    return (f == 6'h20) || (f == 6'h22) || (f == 6'h24) || (f == 6'h25);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_cur = 0;
      m_q.delete();
    end else if (m_q.size() == 0) begin
      if (m_cur == 0) begin
        case (op)
          6'h00:   if (fn_ok(funct)) m_q = '{1, 6, 7}; else m_q = '{1};
          6'h23:   m_q = '{1, 2, 3, 4};
          6'h2b:   m_q = '{1, 2, 5};
          6'h04:   m_q = '{1, 8};
          6'h08:   m_q = '{1, 9, 10};
          6'h02:   m_q = '{1, 11};
          default: m_q = '{1};
        endcase
        m_cur = m_q.pop_front();
      end else begin
        m_cur = 0;
      end
    end else begin
      m_cur = m_q.pop_front();
    end
  end

  function automatic logic [16:0] exp_vec(input int st, input bit rst, input bit z,
                                          input bit last, input logic [5:0] f);
    logic iord, mw, irw, rdst, m2r, rw, sa, pcen;
    logic [1:0] sb, pcs;
    logic [2:0] alu;
    {iord, mw, irw, rdst, m2r, rw, sa, pcen} = 8'b0;
    sb = 2'b00; pcs = 2'b00; alu = 3'b000;
    if (rst) begin
      sb = 2'b01;
      return {iord, mw, irw, rdst, m2r, rw, sa, sb, alu, pcs, pcen, 1'b0};
    end
    case (st)
      0:  begin irw = 1; sb = 2'b01; pcen = 1; end
      1:  sb = 2'b11;
      2:  begin sa = 1; sb = 2'b10; end
      3:  iord = 1;
      4:  begin m2r = 1; rw = 1; end
      5:  begin iord = 1; mw = 1; end
      6:  begin
            sa = 1;
            alu = (f == 6'h22) ? 3'b001 : (f == 6'h24) ? 3'b010 : (f == 6'h25) ? 3'b011 : 3'b000;
          end
      7:  begin rdst = 1; rw = 1; end
      8:  begin sa = 1; alu = 3'b001; pcs = 2'b01; pcen = z; end
      9:  begin sa = 1; sb = 2'b10; end
      10: rw = 1;
      11: begin pcs = 2'b10; pcen = 1; end
      default: ;
    endcase
    return {iord, mw, irw, rdst, m2r, rw, sa, sb, alu, pcs, pcen, last};
  endfunction

  always @(negedge clk) begin
    lit("state", {28'd0, state}, reset ? 32'd0 : m_cur);
    lit("outs", {15'd0, dut_vec},
        {15'd0, exp_vec(m_cur, reset, zero, (m_cur != 0) && (m_q.size() == 0), funct)});
  end

  task automatic cyc(input int es, input bit z);
    @(posedge clk); #1;
    zero = z;
    @(negedge clk);
    lit("seq_state", {28'd0, state}, es);
  endtask

  initial begin
    reset = 1'b1; op = 6'b100011; funct = 6'd0; zero = 1'b0;
    repeat (2) begin
      @(negedge clk);
      lit("rst_state", {28'd0, state}, 0);
      lit("rst_pcen", PCEn, 0);
      lit("rst_irwrite", IRWrite, 0);
      @(posedge clk); #1;
    end
    reset = 1'b0;
    @(negedge clk);
    lit("rel_state", {28'd0, state}, 0);
    lit("rel_irwrite", IRWrite, 1);
    lit("rel_pcen", PCEn, 1);
    lit("rel_srcb", ALUSrcB, 1);
    // lw
    cyc(1, 0); cyc(2, 0);
    cyc(3, 0); lit("lw_iord", IorD, 1);
    cyc(4, 0); lit("lw_regwrite", RegWrite, 1); lit("lw_memtoreg", MemtoReg, 1);
    lit("lw_done", instr_done, 1);
    cyc(0, 0);
    // R-type sub
    op = 6'b000000; funct = 6'b100010;
    cyc(1, 0);
    cyc(6, 0); lit("sub_aluc", ALUControl, 1); lit("sub_srcb", ALUSrcB, 0);
    cyc(7, 0); lit("sub_regdst", RegDst, 1); lit("sub_regwrite", RegWrite, 1);
    cyc(0, 0);
    // beq taken then not taken
    op = 6'b000100;
    cyc(1, 0);
    cyc(8, 1); lit("beq_t_pcen", PCEn, 1); lit("beq_t_pcsrc", PCSrc, 1);
    cyc(0, 0);
    cyc(1, 0);
    cyc(8, 0); lit("beq_nt_pcen", PCEn, 0);
    cyc(0, 0);
    // unsupported then j
    op = 6'b111111;
    cyc(1, 0);
    lit("nop_done", instr_done, 1);
    lit("nop_we", {RegWrite, MemWrite, IRWrite, PCEn}, 0);
    cyc(0, 0);
    op = 6'b000010;
    cyc(1, 0);
    cyc(11, 0); lit("j_pcsrc", PCSrc, 2); lit("j_pcen", PCEn, 1);
    cyc(0, 0);
    // sw interrupted by reset in MEMWRITE
    op = 6'b101011;
    cyc(1, 0); cyc(2, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    lit("sw_rst_memwrite", MemWrite, 0);
    lit("sw_rst_state", {28'd0, state}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    lit("sw_after_state", {28'd0, state}, 0);
    lit("sw_after_irwrite", IRWrite, 1);

    // Random phase
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      zero = 1'($urandom);
      if (reset) reset = 1'($urandom);
      else       reset = ($urandom_range(0, 39) == 0);
      if (m_cur == 0) begin
        case ($urandom_range(0, 8))
          0: op = 6'h23;
          1: op = 6'h2b;
          2: begin
               op = 6'h00;
               case ($urandom_range(0, 3))
                 0: funct = 6'h20;
                 1: funct = 6'h22;
                 2: funct = 6'h24;
                 default: funct = 6'h25;
               endcase
             end
          3: begin op = 6'h00; funct = 6'($urandom); end
          4: op = 6'h04;
          5: op = 6'h08;
          6: op = 6'h02;
          7: op = 6'($urandom);
          default: begin op = 6'h00; funct = 6'h20; end
        endcase
      end
    end
    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
